// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the instruction-memory loader and the instruction
//   memory it fills: memory geometry and the loader FSM state encoding.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  // Instruction memory geometry, shared with the instruction memory itself.
  localparam int IMEM_DEPTH = 64;  // words; also the largest legal load length
  localparam int IMEM_IW    = 22;  // instruction word width
  localparam int IMEM_AW    = 8;   // instruction address width

  // Loader FSM states.
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    LEN   = 4'd1,
    B0    = 4'd2,
    B1    = 4'd3,
    B2    = 4'd4,
    WRITE = 4'd5,
    CSUM  = 4'd6,
    DONE  = 4'd7,
    ERR   = 4'd8
  } state_t;

endpackage : imem_loader_pkg

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Sole write path into the instruction memory. Receives a byte stream
//   (LEN, N x {hi, mid, lo}, CSUM) on a valid/ready handshake, packs each
//   three-byte group into a 22-bit instruction word, writes it, and verifies
//   an XOR checksum over LEN and all data bytes. The CPU is held from reset
//   until a load finishes with a good checksum.
//
// Ports
//   i_clk        clock, all state changes on rising edge
//   i_rst        asynchronous active-high reset
//   i_start      one-cycle pulse; starts a load from IDLE, DONE or ERR
//   i_rx_data    stream byte
//   i_rx_valid   i_rx_data valid (held stable until accepted)
//   o_rx_ready   loader can accept a byte this cycle (registered)
//   o_iw_addr    instruction memory write address
//   o_iw_data    instruction memory write data
//   o_iw_we      instruction memory write enable, one pulse per word
//   o_cpu_hold   1 = CPU held; drops only after a successful load
//   o_done       sticky: load completed with good checksum
//   o_err        sticky: load aborted (bad length, bad byte, bad checksum)
//   o_words      number of words written in the current or last load
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int IW    = IMEM_IW,
  parameter int AW    = IMEM_AW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic          o_rx_ready,
  output logic [AW-1:0] o_iw_addr,
  output logic [IW-1:0] o_iw_data,
  output logic          o_iw_we,
  output logic          o_cpu_hold,
  output logic          o_done,
  output logic          o_err,
  output logic [AW-1:0] o_words
);

  localparam logic [7:0] MAX_N = 8'(DEPTH);

  state_t          r_state;
  logic            r_rx_ready;
  logic [AW-1:0]   r_iw_addr;
  logic [IW-1:0]   r_iw_data;
  logic            r_iw_we;
  logic            r_cpu_hold;
  logic            r_done;
  logic            r_err;
  logic [AW-1:0]   r_words;
  logic [AW-1:0]   r_len;
  logic [7:0]      r_csum;
  logic [IW-9:0]   r_hi_mid;   // hi (6 bits) and mid (8 bits) of the word being packed

  logic            w_accept;
  logic            w_last_word;

  assign w_accept    = i_rx_valid & r_rx_ready;
  assign w_last_word = (r_words + AW'(1)) == r_len;

  // NOTE: all state below updates with non-blocking assignments so every
  // branch sees the pre-edge values; blocking here would create order races.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_rx_ready <= 1'b0;
      r_iw_addr  <= '0;
      r_iw_data  <= '0;
      r_iw_we    <= 1'b0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_words    <= '0;
      r_len      <= '0;
      r_csum     <= '0;
      r_hi_mid   <= '0;
    end else begin
      // Write enable is a single-cycle pulse; only the B2 accept raises it.
      r_iw_we <= 1'b0;

      case (r_state)
        IDLE, DONE, ERR: begin
          if (i_start) begin
            r_state    <= LEN;
            r_rx_ready <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_words    <= '0;
            r_iw_addr  <= '0;
            r_csum     <= '0;
            r_cpu_hold <= 1'b1;
          end
        end

        LEN: begin
          if (w_accept) begin
            r_csum <= r_csum ^ i_rx_data;
            r_len  <= AW'(i_rx_data);
            if (i_rx_data == 8'd0 || i_rx_data > MAX_N) begin
              r_state    <= ERR;
              r_err      <= 1'b1;
              r_rx_ready <= 1'b0;
            end else begin
              r_state <= B0;
            end
          end
        end

        B0: begin
          if (w_accept) begin
            r_csum <= r_csum ^ i_rx_data;
            // Only 6 bits of the hi byte fit in a 22-bit word.
            if (i_rx_data[7:6] != 2'b00) begin
              r_state    <= ERR;
              r_err      <= 1'b1;
              r_rx_ready <= 1'b0;
            end else begin
              r_hi_mid[IW-9:8] <= i_rx_data[5:0];
              r_state          <= B1;
            end
          end
        end

        B1: begin
          if (w_accept) begin
            r_csum        <= r_csum ^ i_rx_data;
            r_hi_mid[7:0] <= i_rx_data;
            r_state       <= B2;
          end
        end

        B2: begin
          if (w_accept) begin
            r_csum     <= r_csum ^ i_rx_data;
            // Present the full word now so the write lands in the WRITE cycle.
            r_iw_data  <= {r_hi_mid, i_rx_data};
            r_iw_we    <= 1'b1;
            r_rx_ready <= 1'b0;
            r_state    <= WRITE;
          end
        end

        WRITE: begin
          r_iw_addr  <= r_iw_addr + AW'(1);
          r_words    <= r_words + AW'(1);
          r_rx_ready <= 1'b1;
          r_state    <= w_last_word ? CSUM : B0;
        end

        CSUM: begin
          if (w_accept) begin
            r_rx_ready <= 1'b0;
            if (i_rx_data == r_csum) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end
          end
        end

        default: begin
          r_state    <= IDLE;
          r_rx_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_ready = r_rx_ready;
  assign o_iw_addr  = r_iw_addr;
  assign o_iw_data  = r_iw_data;
  assign o_iw_we    = r_iw_we;
  assign o_cpu_hold = r_cpu_hold;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_words    = r_words;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed stimulus for imem_loader. Expected memory writes are queued as
//   streams are sent; a negedge monitor pops and compares every IW_WE pulse.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  iw_addr;
  logic [21:0] iw_data;
  logic        iw_we;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [7:0]  words;

  int n_checks = 0;
  int n_errors = 0;

  logic [29:0] exp_q[$];   // {addr, data}
  logic [7:0]  stim[$];

  imem_loader dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_rx_ready (rx_ready),
    .o_iw_addr  (iw_addr),
    .o_iw_data  (iw_data),
    .o_iw_we    (iw_we),
    .o_cpu_hold (cpu_hold),
    .o_done     (done),
    .o_err      (err),
    .o_words    (words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (iw_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_iw_we", {2'b0, iw_addr, iw_data}, 32'hFFFF_FFFF);
      end else begin
        logic [29:0] e;
        e = exp_q.pop_front();
        check("iw_addr", {24'h0, iw_addr}, {24'h0, e[29:22]});
        check("iw_data", {10'h0, iw_data}, {10'h0, e[21:0]});
      end
    end
  end

  task automatic expect_write(input logic [7:0] a, input logic [21:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte, wait (bounded) for ready, let it be accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int cnt;
    for (int g = 0; g < gap; g++) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    cnt = 0;
    while (rx_ready !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (rx_ready !== 1'b1) check("rx_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_stim(input int max_gap);
    for (int i = 0; i < stim.size(); i++)
      send_byte(stim[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e,
                              input logic h, input logic [7:0] w);
    @(negedge clk);
    check({tag, "_done"},     {31'h0, done},     {31'h0, d});
    check({tag, "_err"},      {31'h0, err},      {31'h0, e});
    check({tag, "_cpu_hold"}, {31'h0, cpu_hold}, {31'h0, h});
    check({tag, "_words"},    {24'h0, words},    {24'h0, w});
    check({tag, "_pending"},  exp_q.size(),      32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_hold"}, {31'h0, cpu_hold}, 32'd1);
    check({tag, "_rx_ready"}, {31'h0, rx_ready}, 32'd0);
    check({tag, "_iw_we"},    {31'h0, iw_we},    32'd0);
    check({tag, "_done"},     {31'h0, done},     32'd0);
    check({tag, "_err"},      {31'h0, err},      32'd0);
    check({tag, "_words"},    {24'h0, words},    32'd0);
    check({tag, "_iw_addr"},  {24'h0, iw_addr},  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cs;
    rst = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    #12;
    check_reset_values("por");
    @(negedge clk);
    rst = 1'b0;

    // Good two-word load; checksum 1B.
    pulse_start();
    stim = '{8'h02, 8'h3F, 8'hFF, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h1B};
    expect_write(8'd0, 22'h3FFFFF);
    expect_write(8'd1, 22'h001234);
    send_stim(0);
    check_status("good2", 1'b1, 1'b0, 1'b0, 8'd2);

    // Same stream, wrong checksum: words are still written, then ERR.
    pulse_start();
    stim = '{8'h02, 8'h3F, 8'hFF, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h1C};
    expect_write(8'd0, 22'h3FFFFF);
    expect_write(8'd1, 22'h001234);
    send_stim(0);
    check_status("badcs", 1'b0, 1'b1, 1'b1, 8'd2);

    // Zero length and over-long length.
    pulse_start();
    send_byte(8'h00, 0);
    check_status("len0", 1'b0, 1'b1, 1'b1, 8'd0);
    pulse_start();
    send_byte(8'h41, 0);
    check_status("len65", 1'b0, 1'b1, 1'b1, 8'd0);

    // Illegal hi byte.
    pulse_start();
    stim = '{8'h01, 8'h40};
    send_stim(0);
    check_status("badhi", 1'b0, 1'b1, 1'b1, 8'd0);
    repeat (5) @(negedge clk);
    check("badhi_rx_ready", {31'h0, rx_ready}, 32'd0);

    // N=3 with random valid gaps and an ignored START mid-stream; checksum BF.
    pulse_start();
    stim = '{8'h03, 8'h0A, 8'hBC, 8'hDE, 8'h15, 8'h55};
    expect_write(8'd0, 22'h0ABCDE);
    expect_write(8'd1, 22'h1555AA);
    expect_write(8'd2, 22'h3F0001);
    send_stim(3);
    pulse_start();
    stim = '{8'hAA, 8'h3F, 8'h00, 8'h01, 8'hBF};
    send_stim(3);
    check_status("n3", 1'b1, 1'b0, 1'b0, 8'd3);

    // Reload, reset asynchronously after the first word is written.
    pulse_start();
    stim = '{8'h03, 8'h01, 8'h02, 8'h03};
    expect_write(8'd0, 22'h010203);
    send_stim(0);
    @(negedge clk);   // write cycle, checked by the monitor
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_pending", exp_q.size(), 32'd0);
    check("midrst_rx_ready", {31'h0, rx_ready}, 32'd0);

    // Full N=3 load after the reset.
    pulse_start();
    stim = '{8'h03, 8'h0A, 8'hBC, 8'hDE, 8'h15, 8'h55, 8'hAA, 8'h3F, 8'h00, 8'h01, 8'hBF};
    expect_write(8'd0, 22'h0ABCDE);
    expect_write(8'd1, 22'h1555AA);
    expect_write(8'd2, 22'h3F0001);
    send_stim(0);
    check_status("after_rst", 1'b1, 1'b0, 1'b0, 8'd3);

    // N=DEPTH: word i = {00, 00, i}; last write at address 63.
    pulse_start();
    stim.delete();
    stim.push_back(8'h40);
    cs = 8'h40;
    for (int i = 0; i < 64; i++) begin
      stim.push_back(8'h00);
      stim.push_back(8'h00);
      stim.push_back(8'(i));
      cs = cs ^ 8'(i);
      expect_write(8'(i), 22'(i));
    end
    stim.push_back(cs);
    send_stim(0);
    check_status("depth", 1'b1, 1'b0, 1'b0, 8'd64);
    check("depth_addr_no_wrap", {24'h0, iw_addr}, 32'd64);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_imem_loader
